// File: rtl/lift_shaft_model.sv
// Behavioural lift shaft: turns controller motion/direction/door commands into a
// car position, a one-hot floor sensor vector and sticky safety-violation flags.
module lift_shaft_model #(
  parameter int unsigned N_FLOORS        = 8,
  parameter int unsigned TICKS_PER_FLOOR = 16,
  parameter int unsigned INIT_FLOOR      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_motion,
  input  logic                        i_direction,
  input  logic                        i_door_open,
  output logic [N_FLOORS-1:0]         o_floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] o_floor_idx,
  output logic                        o_between,
  output logic                        o_arrive,
  output logic                        o_fault_limit,
  output logic                        o_fault_door
);

  localparam int unsigned IDX_W = $clog2(N_FLOORS);
  localparam int unsigned OFF_W = $clog2(TICKS_PER_FLOOR);

  localparam logic [IDX_W-1:0]    TOP_IDX   = IDX_W'(N_FLOORS - 1);
  localparam logic [IDX_W-1:0]    INIT_IDX  = IDX_W'(INIT_FLOOR);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [OFF_W-1:0]    OFF_MAX   = OFF_W'(TICKS_PER_FLOOR - 1);
  localparam logic [OFF_W-1:0]    OFF_ONE   = OFF_W'(1);
  localparam logic [N_FLOORS-1:0] SENSE_ONE = N_FLOORS'(1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    FAULT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] floor_idx;
  logic [OFF_W-1:0] offset;
  logic             dir_q;

  // The port is named reset but is active-low: 0 holds the car at INIT_FLOOR.
  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      floor_idx     <= INIT_IDX;
      offset        <= '0;
      dir_q         <= 1'b0;
      o_arrive      <= 1'b0;
      o_fault_limit <= 1'b0;
      o_fault_door  <= 1'b0;
    end else begin
      o_arrive <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_motion) begin
            if (i_door_open) begin
              o_fault_door <= 1'b1;
              state        <= FAULT;
            end else if (i_direction && (floor_idx == TOP_IDX)) begin
              o_fault_limit <= 1'b1;
              state         <= FAULT;
            end else if (!i_direction && (floor_idx == '0)) begin
              o_fault_limit <= 1'b1;
              state         <= FAULT;
            end else begin
              dir_q <= i_direction;
              state <= MOVE;
              // Going down, floor_idx immediately names the floor below the car.
              if (i_direction) begin
                offset <= OFF_ONE;
              end else begin
                floor_idx <= floor_idx - IDX_ONE;
                offset    <= OFF_MAX;
              end
            end
          end
        end

        MOVE: begin
          // Motion and direction are ignored here: the car always coasts to
          // the next floor in the latched direction.
          if (i_door_open) begin
            o_fault_door <= 1'b1;
            state        <= FAULT;
          end else if (dir_q) begin
            if (offset == OFF_MAX) begin
              offset    <= '0;
              floor_idx <= floor_idx + IDX_ONE;
              state     <= IDLE;
              o_arrive  <= 1'b1;
            end else begin
              offset <= offset + OFF_ONE;
            end
          end else begin
            if (offset == OFF_ONE) begin
              offset   <= '0;
              state    <= IDLE;
              o_arrive <= 1'b1;
            end else begin
              offset <= offset - OFF_ONE;
            end
          end
        end

        FAULT: begin
          // Frozen until reset.
        end

        default: state <= FAULT;
      endcase
    end
  end

  // Sensor outputs decode only registered state.
  assign o_floor_sense = (offset == '0) ? (SENSE_ONE << floor_idx) : '0;
  assign o_floor_idx   = floor_idx;
  assign o_between     = (offset != '0);

endmodule

// File: tb/tb_lift_shaft_model.sv
// Self-checking bench for lift_shaft_model: directed scenarios plus random
// command streams compared against a linear tick-position reference model.
module tb_lift_shaft_model;

  localparam int unsigned N  = 4;
  localparam int unsigned T  = 4;
  localparam int unsigned I0 = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_motion = 1'b0;
  logic         i_direction = 1'b0;
  logic         i_door_open = 1'b0;
  logic [N-1:0] o_floor_sense;
  logic [1:0]   o_floor_idx;
  logic         o_between;
  logic         o_arrive;
  logic         o_fault_limit;
  logic         o_fault_door;

  lift_shaft_model #(
    .N_FLOORS       (N),
    .TICKS_PER_FLOOR(T),
    .INIT_FLOOR     (I0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_motion     (i_motion),
    .i_direction  (i_direction),
    .i_door_open  (i_door_open),
    .o_floor_sense(o_floor_sense),
    .o_floor_idx  (o_floor_idx),
    .o_between    (o_between),
    .o_arrive     (o_arrive),
    .o_fault_limit(o_fault_limit),
    .o_fault_door (o_fault_door)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: car position as an absolute tick count from floor 0.
  int m_pos;
  bit m_moving, m_dir, m_stuck, m_arrive, m_flimit, m_fdoor;

  function automatic void model_reset();
    m_pos    = I0 * T;
    m_moving = 0;
    m_dir    = 0;
    m_stuck  = 0;
    m_arrive = 0;
    m_flimit = 0;
    m_fdoor  = 0;
  endfunction

  function automatic void model_edge(input bit mot, input bit dir, input bit door);
    m_arrive = 0;
    if (m_stuck) return;
    if (!m_moving) begin
      if (!mot) return;
      if (door) begin
        m_fdoor = 1; m_stuck = 1;
      end else if (dir && m_pos == (N - 1) * T) begin
        m_flimit = 1; m_stuck = 1;
      end else if (!dir && m_pos == 0) begin
        m_flimit = 1; m_stuck = 1;
      end else begin
        m_moving = 1;
        m_dir    = dir;
        m_pos    = dir ? m_pos + 1 : m_pos - 1;
      end
    end else if (door) begin
      m_fdoor = 1; m_stuck = 1;
    end else begin
      m_pos = m_dir ? m_pos + 1 : m_pos - 1;
      if (m_pos % T == 0) begin
        m_moving = 0;
        m_arrive = 1;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [31:0] exp_sense;
    bit          exp_betw;
    exp_betw  = (m_pos % T) != 0;
    exp_sense = exp_betw ? 32'd0 : (32'd1 << (m_pos / T));
    check({tag, ".sense"},   32'(o_floor_sense), exp_sense);
    check({tag, ".idx"},     32'(o_floor_idx),   32'(m_pos / T));
    check({tag, ".between"}, 32'(o_between),     32'(exp_betw));
    check({tag, ".arrive"},  32'(o_arrive),      32'(m_arrive));
    check({tag, ".flimit"},  32'(o_fault_limit), 32'(m_flimit));
    check({tag, ".fdoor"},   32'(o_fault_door),  32'(m_fdoor));
  endtask

  // Called just after a falling edge; applies inputs across one rising edge.
  task automatic step(input string tag, input bit mot, input bit dir, input bit door);
    i_motion    = mot;
    i_direction = dir;
    i_door_open = door;
    @(posedge clk);
    model_edge(mot, dir, door);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".in_rst"});
    @(negedge clk);
    reset = 1'b1;
    compare_all({tag, ".rel"});
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset("por");
    check("por.sense_const", 32'(o_floor_sense), 32'h1);

    // Hold up from floor 0: arrivals every T edges, limit fault at the top.
    for (int k = 1; k <= 13; k++) begin
      step("uprun", 1, 1, 0);
      if (k == 4) check("uprun.arrive_edge4", 32'(o_arrive), 32'd1);
    end
    check("uprun.limit_const", 32'(o_fault_limit), 32'd1);
    check("uprun.sense_top",   32'(o_floor_sense), 32'h8);
    step("uprun.frozen", 1, 0, 0);

    // Depart up from floor 1, then drop motion and flip direction: car coasts.
    apply_reset("r1");
    for (int k = 0; k < 4; k++) step("to_f1", 1, 1, 0);
    step("dep_f1", 1, 1, 0);
    for (int k = 0; k < 5; k++) step("coast", 0, 0, 0);
    check("coast.idx_const", 32'(o_floor_idx), 32'd2);

    // Door opens mid-travel: door fault, position frozen, then reset clears.
    apply_reset("r2");
    step("door.dep", 1, 1, 0);
    step("door.t1",  1, 1, 0);
    step("door.open", 1, 1, 1);
    for (int k = 0; k < 3; k++) step("door.frozen", 1, 1, 0);
    check("door.between_const", 32'(o_between), 32'd1);
    check("door.fdoor_const",   32'(o_fault_door), 32'd1);
    apply_reset("r3");
    check("r3.idx_const", 32'(o_floor_idx), 32'd0);

    // Down command at the bottom floor.
    step("bottom", 1, 0, 0);
    check("bottom.limit_const", 32'(o_fault_limit), 32'd1);
    check("bottom.idx_const",   32'(o_floor_idx), 32'd0);

    // Randomised command streams with occasional resets (also mid-travel).
    apply_reset("r4");
    for (int k = 0; k < 3000; k++) begin
      bit mot, dir, door;
      if (($urandom_range(0, 199) == 0) || (m_stuck && $urandom_range(0, 9) == 0)) begin
        apply_reset("rnd.rst");
      end else begin
        mot  = ($urandom_range(0, 3) != 0);
        dir  = (m_pos == 0) ? ($urandom_range(0, 7) != 0)
             : (m_pos == (N - 1) * T) ? ($urandom_range(0, 7) == 0)
             : 1'($urandom_range(0, 1));
        door = ($urandom_range(0, 59) == 0);
        step("rnd", mot, dir, door);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
